y86_fetch_queue: RTL and testbench

Parametrised successor to the SEQ fetch stage for the pipelined Y86-64 core. It decouples instruction memory from decode. W-byte blocks are prefetched from a 1-cycle-latency instruction memory into a circular byte queue. Variable-length instructions are extracted at the queue head and presented to decode over a valid/ready handshake. A redirect port flushes the queue and restarts fetch at a new PC.

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/y86_byte_queue.sv | 57 +++++
 rtl/y86_fetch_queue.sv | 174 +++++++++++++++++
 tb/tb_y86_fetch_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 fetch constants and instruction length helper
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [7:0] STAT_AOK = 8'h01;
    localparam logic [7:0] STAT_HLT = 8'h02;
    localparam logic [7:0] STAT_ADR = 8'h04;
    localparam logic [7:0] STAT_INS = 8'h08;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_STOP = 1'b1
    } fq_state_t;

    // Encoded length in bytes; invalid icodes occupy one byte so they can be reported
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:                instr_len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    instr_len = 4'd2;
            I_JXX, I_CALL:                       instr_len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        instr_len = 4'd10;
            default:                             instr_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/y86_byte_queue.sv
// rtl/y86_byte_queue.sv - circular byte queue, block push and variable-length head pop
module y86_byte_queue #(
    parameter int FETCH_W = 8,
    parameter int DEPTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [8*FETCH_W-1:0]     push_data,
    input  logic                     pop_valid,
    input  logic [3:0]               pop_len,
    output logic [79:0]              head_bytes,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    storage [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;

    // Write one fetch block at the tail; the issuer guarantees room, so no overwrite check here
    always_ff @(posedge clk) begin
        if (push_valid) begin
            for (int i = 0; i < FETCH_W; i++) begin
                storage[wr_ptr + AW'(i)] <= push_data[8*i +: 8];
            end
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop in the same edge
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_valid) wr_ptr <= wr_ptr + AW'(FETCH_W);
            if (pop_valid)  rd_ptr <= rd_ptr + AW'(pop_len);
            count_q <= count_q
                     + (push_valid ? (AW+1)'(FETCH_W) : '0)
                     - (pop_valid  ? (AW+1)'(pop_len) : '0);
        end
    end

    // Longest instruction is 10 bytes, so expose a 10-byte window at the head
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            head_bytes[8*i +: 8] = storage[rd_ptr + AW'(i)];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/y86_fetch_queue.sv
// rtl/y86_fetch_queue.sv - prefetching fetch stage with byte queue and record extraction
module y86_fetch_queue
    import y86_pkg::*;
#(
    parameter int          FETCH_W  = 8,
    parameter int          DEPTH    = 32,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req_valid,
    output logic [63:0]            mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [8*FETCH_W-1:0]   mem_rsp_data,
    input  logic                   mem_rsp_err,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             icode,
    output logic [3:0]             ifun,
    output logic [3:0]             rA,
    output logic [3:0]             rB,
    output logic [63:0]            valC,
    output logic [63:0]            valP,
    output logic [63:0]            instr_pc,
    output logic [7:0]             stat
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_t     state_q, state_d;
    logic [63:0]   fetch_pc;
    logic [63:0]   head_pc;
    logic          inflight;
    logic          err_flag;

    logic [79:0]   hb;
    logic [CW-1:0] count;
    logic [3:0]    len;
    logic          have_all;
    logic          adr_rec;
    logic          rec_valid;
    logic          fire;
    logic          rsp_accept;
    logic          issue;
    logic [CW+1:0] credit_sum;
    logic          credit_ok;

    logic [3:0]    r_icode, r_ifun, r_ra, r_rb;
    logic [63:0]   r_valc, r_valp;
    logic [7:0]    r_stat;

    y86_byte_queue #(
        .FETCH_W (FETCH_W),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push_valid (rsp_accept && !mem_rsp_err),
        .push_data  (mem_rsp_data),
        .pop_valid  (fire && !adr_rec),
        .pop_len    (len),
        .head_bytes (hb),
        .count      (count)
    );

    // Credit check: reserve room for the in-flight block and the one about to be requested
    always_comb begin
        credit_sum = {2'b00, count} + (CW+2)'(FETCH_W) + (inflight ? (CW+2)'(FETCH_W) : '0);
        credit_ok  = credit_sum <= (CW+2)'(DEPTH);
        issue      = rst_n && (state_q == S_RUN) && !err_flag && !redirect_valid && credit_ok;
        // inflight doubles as the epoch: it is cleared by redirect/reset so a stale reply is ignored
        rsp_accept = mem_rsp_valid && inflight && !err_flag;
    end

    // Head decode: length, availability and the ADR case when bytes can never arrive
    always_comb begin
        len       = instr_len(hb[7:4]);
        have_all  = count >= CW'(len);
        adr_rec   = err_flag && !have_all;
        rec_valid = rst_n && (state_q == S_RUN) && !redirect_valid && (have_all || adr_rec);
        fire      = rec_valid && out_ready;
    end

    // Field extraction from the head window
    always_comb begin
        r_icode = hb[7:4];
        r_ifun  = hb[3:0];
        r_ra    = RNONE;
        r_rb    = RNONE;
        r_valc  = '0;
        r_stat  = STAT_AOK;
        r_valp  = head_pc + 64'(len);
        if (len == 4'd2 || len == 4'd10) begin
            r_ra = hb[15:12];
            r_rb = hb[11:8];
        end
        if (len == 4'd10)     r_valc = hb[79:16];
        else if (len == 4'd9) r_valc = hb[71:8];
        if (hb[7:4] == I_HALT)      r_stat = STAT_HLT;
        else if (hb[7:4] > I_POPQ)  r_stat = STAT_INS;
        if (adr_rec) begin
            r_icode = I_HALT;
            r_ifun  = 4'h0;
            r_ra    = RNONE;
            r_rb    = RNONE;
            r_valc  = '0;
            r_valp  = head_pc;
            r_stat  = STAT_ADR;
        end
    end

    // Output drive; everything reads as zero while reset is asserted
    always_comb begin
        mem_req_valid = issue;
        out_valid     = rec_valid;
        mem_req_addr  = '0;
        icode         = '0;
        ifun          = '0;
        rA            = '0;
        rB            = '0;
        valC          = '0;
        valP          = '0;
        instr_pc      = '0;
        stat          = '0;
        if (rst_n) begin
            mem_req_addr = fetch_pc;
            icode        = r_icode;
            ifun         = r_ifun;
            rA           = r_ra;
            rB           = r_rb;
            valC         = r_valc;
            valP         = r_valp;
            instr_pc     = head_pc;
            stat         = r_stat;
        end
    end

    // Next state: redirect restarts, accepting any non-AOK record stops
    always_comb begin
        state_d = state_q;
        if (redirect_valid)                state_d = S_RUN;
        else if (fire && r_stat != STAT_AOK) state_d = S_STOP;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // PCs, in-flight tracking and sticky memory error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            inflight <= 1'b0;
            err_flag <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            head_pc  <= redirect_pc;
            inflight <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue)                     fetch_pc <= fetch_pc + 64'(FETCH_W);
            if (rsp_accept && mem_rsp_err) err_flag <= 1'b1;
            if (fire)                      head_pc  <= r_valp;
        end
    end

endmodule

// File: tb/tb_y86_fetch_queue.sv
// tb/tb_y86_fetch_queue.sv - table-driven scoreboard bench for y86_fetch_queue
module tb_y86_fetch_queue;
    import y86_pkg::*;

    localparam int W = 8;
    localparam int D = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req_valid;
    logic [63:0]   mem_req_addr;
    logic          mem_rsp_valid = 1'b0;
    logic [8*W-1:0] mem_rsp_data = '0;
    logic          mem_rsp_err = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [63:0]   redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    icode, ifun, rA, rB;
    logic [63:0]   valC, valP, instr_pc;
    logic [7:0]    stat;

    always #5 clk = ~clk;

    y86_fetch_queue #(.FETCH_W(W), .DEPTH(D), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_pc(instr_pc), .stat(stat)
    );

    typedef struct packed {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, pc;
        logic [7:0]  stat;
    } rec_t;

    typedef struct {
        int          seg;
        int          nb;
        logic [79:0] bytes;
        rec_t        exp;
    } vec_t;

    vec_t        vt[$];
    rec_t        sb[$];
    logic [7:0]  img [512];
    logic [63:0] err_limit = 64'd512;
    int          n_vec = 0;
    int          n_bad = 0;
    int          req_count = 0;
    logic        pend_v = 1'b0;
    logic [63:0] pend_a = '0;
    logic [8:0]  rsp_idx;

    // Memory model: capture the request mid-cycle, answer in the following cycle
    always @(negedge clk) begin
        pend_v = mem_req_valid;
        pend_a = mem_req_addr;
        if (mem_req_valid) req_count++;
    end

    always @(posedge clk) begin
        #1;
        mem_rsp_valid = pend_v;
        mem_rsp_err   = 1'b0;
        mem_rsp_data  = '0;
        if (pend_v) begin
            if (pend_a + 64'(W) > err_limit) mem_rsp_err = 1'b1;
            else begin
                for (int i = 0; i < W; i++) begin
                    rsp_idx = pend_a[8:0] + 9'(i);
                    mem_rsp_data[8*i +: 8] = img[rsp_idx];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic to_neg();
        rec_t got, e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            got = {icode, ifun, rA, rB, valC, valP, instr_pc, stat};
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_record: got %0h, want none", got);
            end else begin
                e = sb.pop_front();
                chk($sformatf("record@%0h", e.pc), got, e);
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        to_neg();
        to_pos();
    endtask

    task automatic add(input int seg, input logic [63:0] pc, input int nb, input logic [79:0] bytes,
                       input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp, input logic [7:0] st);
        vec_t v;
        v.seg   = seg;
        v.nb    = nb;
        v.bytes = bytes;
        v.exp   = {ic, fn, ra, rb, valc, valp, pc, st};
        vt.push_back(v);
    endtask

    task automatic load_seg(input int s);
        logic [8:0] ia;
        for (int a = 0; a < 512; a++) img[a] = 8'h00;
        foreach (vt[k]) begin
            if (vt[k].seg == s) begin
                for (int j = 0; j < vt[k].nb; j++) begin
                    ia = vt[k].exp.pc[8:0] + 9'(j);
                    img[ia] = vt[k].bytes[8*j +: 8];
                end
                sb.push_back(vt[k].exp);
            end
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            step();
            k++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic check_stopped(input string name);
        logic seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            to_neg();
            seen = seen | out_valid | mem_req_valid;
            to_pos();
        end
        chk(name, seen, 0);
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        to_neg();
        chk("redirect_quiet", {out_valid, mem_req_valid}, 0);
        to_pos();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int base;

        add(1, 64'h00, 10, 80'h0100F030, 4'h3, 4'h0, 4'hF, 4'h0, 64'h100, 64'd10, STAT_AOK);
        add(1, 64'h0A, 1,  80'h00,       4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'd11, STAT_HLT);
        add(2, 64'h00, 1,  80'h10,       4'h1, 4'h0, 4'hF, 4'hF, 64'h0,   64'd1,  STAT_AOK);
        add(2, 64'h01, 2,  80'h0160,     4'h6, 4'h0, 4'h0, 4'h1, 64'h0,   64'd3,  STAT_AOK);
        add(2, 64'h03, 1,  80'h90,       4'h9, 4'h0, 4'hF, 4'hF, 64'h0,   64'd4,  STAT_AOK);
        add(2, 64'h04, 9,  80'h4070,     4'h7, 4'h0, 4'hF, 4'hF, 64'h40,  64'd13, STAT_AOK);
        add(2, 64'h0D, 1,  80'h00,       4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'd14, STAT_HLT);
        add(3, 64'h40, 2,  80'h1220,     4'h2, 4'h0, 4'h1, 4'h2, 64'h0,   64'h42, STAT_AOK);
        add(3, 64'h42, 1,  80'h00,       4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'h43, STAT_HLT);
        add(4, 64'h20, 1,  80'h00,       4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'h21, STAT_HLT);
        add(5, 64'h00, 1,  80'hC0,       4'hC, 4'h0, 4'hF, 4'hF, 64'h0,   64'h1,  STAT_INS);
        for (int k = 0; k < 6; k++)
            add(6, 64'h10 + 64'(k), 1, 80'h10, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h11 + 64'(k), STAT_AOK);
        add(6, 64'h16, 10, 80'h08F230,   4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'h16, STAT_ADR);
        add(7, 64'h00, 1,  80'hC0,       4'hC, 4'h0, 4'hF, 4'hF, 64'h0,   64'h1,  STAT_INS);

        // Power-up reset, then a 10-byte irmovq spanning two blocks
        load_seg(1);
        to_neg();
        chk("reset_outputs", {mem_req_valid, mem_req_addr, out_valid, icode, ifun, rA, rB,
                              valC, valP, instr_pc, stat}, 0);
        to_pos();
        step();
        rst_n = 1'b1;
        to_neg();
        chk("first_req", {mem_req_valid, mem_req_addr}, {1'b1, 64'h0});
        to_pos();
        drain("seg1_drain");
        check_stopped("seg1_stop");

        // Consumer stall: credit limit, first-record latency, then in-order delivery
        out_ready = 1'b0;
        load_seg(2);
        redirect_to(64'h0);
        base = req_count;
        for (int i = 0; i < 12; i++) begin
            to_neg();
            if (i == 1)  chk("first_rec_early", out_valid, 0);
            if (i == 2)  chk("first_rec_latency", out_valid, 1);
            if (i == 11) chk("credit_stall", mem_req_valid, 0);
            to_pos();
        end
        chk("credit_requests", req_count - base, D / W);
        out_ready = 1'b1;
        drain("seg2_drain");
        check_stopped("seg2_stop");

        // Redirect while a response is in flight and a record is pending
        out_ready = 1'b0;
        load_seg(3);
        for (int a = 0; a < 64; a++) img[a] = 8'h10;
        redirect_to(64'h0);
        step();
        step();
        out_ready = 1'b1;
        redirect_to(64'h40);
        drain("seg3_drain");
        check_stopped("seg3_stop");

        // Halt mid-memory
        load_seg(4);
        redirect_to(64'h20);
        drain("seg4_drain");
        check_stopped("hlt_stop");

        // Invalid icode
        load_seg(5);
        redirect_to(64'h0);
        drain("seg5_drain");
        check_stopped("ins_stop");

        // Instruction straddling into an erroring block
        load_seg(6);
        err_limit = 64'h18;
        redirect_to(64'h10);
        drain("seg6_drain");
        check_stopped("adr_stop");

        // Reset in the middle of streaming with a response in flight
        err_limit = 64'd512;
        out_ready = 1'b0;
        load_seg(7);
        for (int a = 64; a < 128; a++) img[a] = 8'h10;
        redirect_to(64'h40);
        step();
        step();
        rst_n = 1'b0;
        to_neg();
        chk("midreset_outputs", {mem_req_valid, mem_req_addr, out_valid, icode, ifun, rA, rB,
                                 valC, valP, instr_pc, stat}, 0);
        to_pos();
        rst_n = 1'b1;
        to_neg();
        chk("restart_req", {mem_req_valid, mem_req_addr}, {1'b1, 64'h0});
        to_pos();
        out_ready = 1'b1;
        drain("seg7_drain");
        check_stopped("seg7_stop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
